// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command bus.
// Command word layout (32 bits):
//   [31:26] component  [25:21] reserved  [20:17] action
//   [16:14] action_type  [13] buffer_toggle  [12:0] data
package sprite_cmd_pkg;

  localparam int CMD_W      = 32;
  localparam int COMP_LSB   = 26;
  localparam int ACTION_LSB = 17;
  localparam int ACTION_MSB = 20;
  localparam int ATYPE_LSB  = 14;
  localparam int TOGGLE_BIT = 13;

  localparam logic [3:0] ACTION_NOP    = 4'b0000;
  localparam logic [3:0] ACTION_UPDATE = 4'b0001;
  localparam logic [3:0] ACTION_COMMIT = 4'b1110;
  localparam logic [3:0] ACTION_SWAP   = 4'b1111;

  localparam logic [5:0] COMP_GLOBAL = 6'd0;
  localparam logic [5:0] COMP_MARIO  = 6'd1;
  localparam logic [5:0] COMP_LUIGI  = 6'd2;
  localparam logic [5:0] COMP_BOWSER = 6'd9;

  typedef struct packed {
    logic [5:0]  component;
    logic [4:0]  rsvd;
    logic [3:0]  action;
    logic [2:0]  action_type;
    logic        buffer_toggle;
    logic [12:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE       = 2'd1,
    ST_WAIT_VBLANK = 2'd2,
    ST_SWAP        = 2'd3
  } sched_state_e;

  // Global flip word: every component swaps ping/pong when it sees this.
  function automatic cmd_t swap_word(input logic back);
    cmd_t w;
    w               = '0;
    w.component     = COMP_GLOBAL;
    w.action        = ACTION_SWAP;
    w.buffer_toggle = back;
    return w;
  endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Single-clock command FIFO.
//   clk, rst_n      : clock, async active-low reset
//   push_i, wdata_i : enqueue (caller guarantees !full_o)
//   pop_i           : dequeue head (caller guarantees !empty_o)
//   head_o          : current head entry
//   full_o, empty_o : occupancy flags
//   count_o         : occupancy, 0..DEPTH
module sprite_cmd_fifo
  import sprite_cmd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  cmd_t                     wdata_i,
  input  logic                     pop_i,
  output cmd_t                     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Host-to-sprite command scheduler with tear-free double-buffer swaps.
//   clk, reset            : clock, async active-low reset
//   writedata/write/chipselect : host command port
//   hcount, vcount        : raster position (vcount drives vblank detect)
//   cmd_writedata, cmd_valid   : broadcast command bus (zero when idle)
//   fifo_full, overflow   : FIFO full, sticky dropped-write flag
//   frame_pending         : a commit is queued or waiting for vblank
//   front_buf, frame_count: displayed buffer, number of swaps issued
module sprite_frame_scheduler
  import sprite_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int V_ACTIVE    = 480,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            writedata,
  input  logic                   write,
  input  logic                   chipselect,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  output logic [31:0]            cmd_writedata,
  output logic                   cmd_valid,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   frame_pending,
  output logic                   front_buf,
  output logic [FRAME_CNT_W-1:0] frame_count
);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0]  V_ACT_L  = V_ACTIVE[9:0];
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Async assert, sync deassert of the internal reset.
  logic rst_s1_q, rst_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {rst_s1_q, rst_n} <= 2'b00;
    else        {rst_s1_q, rst_n} <= {1'b1, rst_s1_q};
  end

  logic unused_hcount;
  assign unused_hcount = ^hcount;

  // Host decode
  logic [3:0] wr_action;
  logic       host_wr, push, commit_in, drop;
  cmd_t       fifo_head;
  logic       fifo_empty, fifo_full_w;
  logic [CW-1:0] fifo_cnt;

  assign wr_action = writedata[ACTION_MSB:ACTION_LSB];
  assign host_wr   = write & chipselect;
  // Full is judged before any same-cycle pop, so a pop never rescues a write.
  assign drop      = host_wr & ((wr_action == ACTION_SWAP) | fifo_full_w);
  assign push      = host_wr & ~drop;
  assign commit_in = push & (wr_action == ACTION_COMMIT);

  // Vblank edge: one pulse per frame independent of pixel-clock ratio.
  logic in_vblank_q, in_vblank_d_q, vblank_rise;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vblank_q   <= 1'b0;
      in_vblank_d_q <= 1'b0;
    end else begin
      in_vblank_q   <= (vcount >= V_ACT_L);
      in_vblank_d_q <= in_vblank_q;
    end
  end
  assign vblank_rise = in_vblank_q & ~in_vblank_d_q;

  // FSM
  sched_state_e state_q, state_d;
  logic issue_go, swap_go, pop;
  cmd_t cmd_q, cmd_d;
  logic valid_q, valid_d;
  logic front_q, back_q, ovf_q;
  logic [FRAME_CNT_W-1:0] fc_q;
  logic [CW-1:0] pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue_go = 1'b0;
    swap_go  = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (fifo_empty)                              state_d = ST_IDLE;
        else if (fifo_head.action == ACTION_COMMIT)  state_d = ST_WAIT_VBLANK;
        else begin
          issue_go = 1'b1;
          // Only entries already queued keep us here; a word arriving on
          // this edge goes through IDLE, matching the empty-FIFO latency.
          state_d  = (fifo_cnt > CNT_ONE) ? ST_ISSUE : ST_IDLE;
        end
      end
      ST_WAIT_VBLANK: if (vblank_rise) begin
        swap_go = 1'b1;
        state_d = ST_SWAP;
      end
      ST_SWAP: state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d   = '0;
    valid_d = 1'b0;
    if (issue_go) begin
      cmd_d               = fifo_head;
      cmd_d.buffer_toggle = back_q;
      valid_d             = 1'b1;
    end else if (swap_go) begin
      cmd_d   = swap_word(back_q);
      valid_d = 1'b1;
    end
  end

  assign pop = issue_go | swap_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_q <= 1'b0;
      back_q  <= 1'b1;
      fc_q    <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      if (swap_go) begin
        front_q <= back_q;
        back_q  <= ~back_q;
        fc_q    <= fc_q + FRAME_CNT_W'(1);
      end
      case ({commit_in, swap_go})
        2'b10:   pend_q <= pend_q + CNT_ONE;
        2'b01:   pend_q <= pend_q - CNT_ONE;
        default: pend_q <= pend_q;
      endcase
    end
  end

  sprite_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (cmd_t'(writedata)),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign cmd_writedata = cmd_q;
  assign cmd_valid     = valid_q;
  assign fifo_full     = fifo_full_w;
  assign overflow      = ovf_q;
  assign frame_pending = (pend_q != '0);
  assign front_buf     = front_q;
  assign frame_count   = fc_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
module tb_sprite_frame_scheduler;
  localparam int DEPTH = 16;
  localparam int FCW   = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [31:0]    writedata = '0;
  logic           write = 1'b0, chipselect = 1'b0;
  logic [9:0]     hcount = '0, vcount = 10'd100;
  logic [31:0]    cmd_writedata;
  logic           cmd_valid, fifo_full, overflow, frame_pending, front_buf;
  logic [FCW-1:0] frame_count;

  always #5 clk = ~clk;

  sprite_frame_scheduler #(.FIFO_DEPTH(DEPTH), .V_ACTIVE(480), .FRAME_CNT_W(FCW)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .hcount(hcount), .vcount(vcount),
    .cmd_writedata(cmd_writedata), .cmd_valid(cmd_valid), .fifo_full(fifo_full),
    .overflow(overflow), .frame_pending(frame_pending), .front_buf(front_buf),
    .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each queued word becomes eligible at max(enqueue edge + 2, gate), where
  // gate is one edge after the previous issued word, or two edges after a
  // swap. A commit at the head waits for the first vblank rise after it
  // became eligible; the swap word goes out on the following edge.
  typedef struct { logic [31:0] w; int enq; } ent_t;
  ent_t        mq[$];
  int          cyc = 0;
  int          m_gate;
  bit          m_wait, m_front, m_back, m_ovf, inv1, inv2, ev;
  logic [FCW-1:0] m_fc;
  logic [31:0] ec;

  task automatic model_reset();
    mq.delete();
    m_gate = 0; m_wait = 0; m_front = 0; m_back = 1; m_ovf = 0;
    m_fc = '0; ec = '0; ev = 0; inv1 = 0; inv2 = 0;
  endtask

  function automatic bit any_commit();
    foreach (mq[i]) if (mq[i].w[20:17] == 4'hE) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int sz0;
    bit rise;
    logic [31:0] h;
    if (!reset) begin model_reset(); return; end
    sz0  = mq.size();
    rise = inv1 && !inv2;
    ev = 0; ec = '0;
    if (m_wait) begin
      if (rise) begin
        ec = 32'h001E_0000 | (32'(m_back) << 13);
        ev = 1;
        m_front = m_back;
        m_back  = !m_back;
        m_fc    = m_fc + 1'b1;
        void'(mq.pop_front());
        m_wait  = 0;
        m_gate  = cyc + 2;
      end
    end else if (sz0 > 0 && mq[0].enq + 2 <= cyc && m_gate <= cyc) begin
      h = mq[0].w;
      if (h[20:17] == 4'hE) m_wait = 1;
      else begin
        ec = {h[31:14], m_back, h[12:0]};
        ev = 1;
        void'(mq.pop_front());
        m_gate = cyc + 1;
      end
    end
    if (write && chipselect) begin
      if (writedata[20:17] == 4'hF || sz0 == DEPTH) m_ovf = 1;
      else mq.push_back('{writedata, cyc});
    end
    inv2 = inv1;
    inv1 = (vcount >= 10'd480);
  endtask

  // Compare process: model advances on each edge, DUT sampled 1ns later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk); #1;
      cyc++;
      model_step();
      chk("cmd_writedata", cmd_writedata, ec);
      chk("cmd_valid", 32'(cmd_valid), 32'(ev));
      chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_pending", 32'(frame_pending), 32'(any_commit()));
      chk("front_buf", 32'(front_buf), 32'(m_front));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #2; endtask
  task automatic drv_wr(input logic [31:0] d);
    write = 1'b1; chipselect = 1'b1; writedata = d;
  endtask
  task automatic drv_idle(); write = 1'b0; chipselect = 1'b0; writedata = '0; endtask
  task automatic idle(input int k); repeat (k) begin step(); drv_idle(); end endtask
  task automatic set_vc(input int v); vcount = 10'(v); endtask
  task automatic do_reset();
    reset = 1'b0; drv_idle(); set_vc(100);
    step(); step();
    reset = 1'b1;
    idle(4);
  endtask

  localparam logic [31:0] COMMIT_W = 32'h001C_0000;

  initial begin
    logic [31:0] d;
    int vc;
    // Reset held with host writes active
    for (int i = 0; i < 3; i++) begin step(); drv_wr(32'h2402_4000 | i); end
    chk("rst cmd", cmd_writedata, 32'h0);
    chk("rst valid", 32'(cmd_valid), 32'h0);
    chk("rst front", 32'(front_buf), 32'h0);
    chk("rst fc", 32'(frame_count), 32'h0);
    chk("rst pend", 32'(frame_pending), 32'h0);
    chk("rst ovf", 32'(overflow), 32'h0);
    drv_idle(); step(); reset = 1'b1; idle(4);

    // Update pass-through and latency
    step(); drv_wr(32'h2402_4064);
    step(); drv_idle();
    step(); chk("lat N+1 valid", 32'(cmd_valid), 32'h0);
    step(); chk("lat N+2 valid", 32'(cmd_valid), 32'h1);
    chk("lat N+2 data", cmd_writedata, 32'h2402_6064);
    step(); chk("bus idle", cmd_writedata, 32'h0);
    idle(3);

    // Three updates, commit, then an update that must wait for the swap
    step(); drv_wr(32'h2402_4001);
    step(); drv_wr(32'h0802_4002);
    step(); drv_wr(32'h2402_4003);
    step(); drv_wr(COMMIT_W);
    step(); drv_wr(32'h2402_6064);
    idle(10);
    chk("wait valid", 32'(cmd_valid), 32'h0);
    chk("wait pend", 32'(frame_pending), 32'h1);
    chk("wait fc", 32'(frame_count), 32'h0);
    set_vc(480);
    step(); chk("rise edge valid", 32'(cmd_valid), 32'h0);
    step(); chk("swap word", cmd_writedata, 32'h001E_2000);
    chk("swap front", 32'(front_buf), 32'h1);
    chk("swap fc", 32'(frame_count), 32'h1);
    step(); chk("post swap gap", 32'(cmd_valid), 32'h0);
    step(); chk("held update", cmd_writedata, 32'h2402_4064);
    chk("pend cleared", 32'(frame_pending), 32'h0);
    set_vc(100); idle(4);

    // Overflow: 17 writes while a commit waits
    step(); drv_wr(COMMIT_W);
    for (int i = 1; i < 17; i++) begin step(); drv_wr(32'h2402_4100 | i); end
    idle(2);
    chk("ovf full", 32'(fifo_full), 32'h1);
    chk("ovf flag", 32'(overflow), 32'h1);
    set_vc(480); idle(25);
    chk("ovf sticky", 32'(overflow), 32'h1);
    chk("drained", 32'(fifo_full), 32'h0);
    set_vc(100); idle(3);

    // Reset in the middle of a vblank wait
    step(); drv_wr(COMMIT_W);
    idle(5);
    reset = 1'b0; #1;
    chk("midrst valid", 32'(cmd_valid), 32'h0);
    chk("midrst fc", 32'(frame_count), 32'h0);
    chk("midrst ovf", 32'(overflow), 32'h0);
    chk("midrst pend", 32'(frame_pending), 32'h0);
    chk("midrst front", 32'(front_buf), 32'h0);
    step(); step(); reset = 1'b1; idle(4);

    // Host swap action is never forwarded
    step(); drv_wr(32'h001E_0000);
    idle(4);
    chk("swap act ovf", 32'(overflow), 32'h1);
    chk("swap act pend", 32'(frame_pending), 32'h0);

    // Two queued commits consume two vblank rises
    do_reset();
    step(); drv_wr(COMMIT_W);
    step(); drv_wr(COMMIT_W);
    idle(5);
    set_vc(480); step(); step();
    chk("dbl1 front", 32'(front_buf), 32'h1);
    chk("dbl1 fc", 32'(frame_count), 32'h1);
    chk("dbl1 pend", 32'(frame_pending), 32'h1);
    set_vc(100); idle(3);
    set_vc(480); step(); step();
    chk("dbl2 front", 32'(front_buf), 32'h0);
    chk("dbl2 fc", 32'(frame_count), 32'h2);
    chk("dbl2 pend", 32'(frame_pending), 32'h0);
    set_vc(100); idle(3);

    // Randomized traffic against the model
    vc = 100;
    for (int i = 0; i < 2500; i++) begin
      int r;
      step();
      d = $urandom();
      r = $urandom_range(0, 99);
      if (r < 8)       d[20:17] = 4'hE;
      else if (r < 11) d[20:17] = 4'hF;
      else if (r < 80) d[20:17] = 4'h1;
      write      = ($urandom_range(0, 2) != 0);
      chipselect = ($urandom_range(0, 3) != 0);
      writedata  = d;
      hcount     = 10'($urandom_range(0, 799));
      vc = (vc + $urandom_range(0, 30)) % 525;
      set_vc(vc);
    end
    drv_idle(); idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
